// File: rtl/axil_reg_slave_pkg.sv
// Shared AXI4-lite definitions: response codes and a constant clog2 helper.
package axil_defs;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/axil_wr_join.sv
// Joins the independent AW and W channels into a single commit strobe with address/data/strobe.
module axil_wr_join #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic                  stall,
   output logic                  commit,
   output logic [ADDR_WIDTH-1:0] commit_addr,
   output logic [DATA_WIDTH-1:0] commit_data,
   output logic [STRB_WIDTH-1:0] commit_strb
);

   logic                  aw_hold_q, aw_hold_d;
   logic                  w_hold_q, w_hold_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic                  aw_fire, w_fire;

   assign awready = !aw_hold_q && !stall;
   assign wready  = !w_hold_q && !stall;
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   // A channel counts as available whether it was held earlier or handshakes on this edge.
   assign commit      = (aw_hold_q || aw_fire) && (w_hold_q || w_fire);
   assign commit_addr = aw_hold_q ? addr_q : awaddr;
   assign commit_data = w_hold_q ? data_q : wdata;
   assign commit_strb = w_hold_q ? strb_q : wstrb;

   always_comb begin
      aw_hold_d = aw_hold_q;
      w_hold_d  = w_hold_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      if (commit) begin
         aw_hold_d = 1'b0;
         w_hold_d  = 1'b0;
      end else begin
         if (aw_fire) begin
            aw_hold_d = 1'b1;
            addr_d    = awaddr;
         end
         if (w_fire) begin
            w_hold_d = 1'b1;
            data_d   = wdata;
            strb_d   = wstrb;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_hold_q <= 1'b0;
         w_hold_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else begin
         aw_hold_q <= aw_hold_d;
         w_hold_q  <= w_hold_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
      end
   end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-lite register bank slave. Define AXIL_REG_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_reg_slave
   import axil_defs::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    STRB_WIDTH  = DATA_WIDTH/8,
   parameter int                    REG_COUNT   = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
   input  logic [2:0]                      s_axil_awprot,
   input  logic                            s_axil_awvalid,
   output logic                            s_axil_awready,
   input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
   input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
   input  logic                            s_axil_wvalid,
   output logic                            s_axil_wready,
   output logic [1:0]                      s_axil_bresp,
   output logic                            s_axil_bvalid,
   input  logic                            s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
   input  logic [2:0]                      s_axil_arprot,
   input  logic                            s_axil_arvalid,
   output logic                            s_axil_arready,
   output logic [DATA_WIDTH-1:0]           s_axil_rdata,
   output logic [1:0]                      s_axil_rresp,
   output logic                            s_axil_rvalid,
   input  logic                            s_axil_rready,
   output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
   output logic [REG_COUNT-1:0]            reg_wr_pulse
);

   localparam int ADDR_LSB = clog2(STRB_WIDTH);
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
`ifdef AXIL_REG_SLVERR_EN
   localparam logic [1:0] ERR_RESP = AXIL_RESP_SLVERR;
`else
   localparam logic [1:0] ERR_RESP = AXIL_RESP_OKAY;
`endif

   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic [REG_COUNT-1:0]  pulse_q, pulse_d;
   logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  wr_commit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic                  wr_hit, rd_hit, ar_fire;
   logic                  unused_ok;

   axil_wr_join #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
   ) u_wr_join (
      .clk         (clk),
      .rst_n       (rst_n),
      .awaddr      (s_axil_awaddr),
      .awvalid     (s_axil_awvalid),
      .awready     (s_axil_awready),
      .wdata       (s_axil_wdata),
      .wstrb       (s_axil_wstrb),
      .wvalid      (s_axil_wvalid),
      .wready      (s_axil_wready),
      .stall       (bvalid_q),
      .commit      (wr_commit),
      .commit_addr (wr_addr),
      .commit_data (wr_data),
      .commit_strb (wr_strb)
   );

   assign wr_idx  = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
   assign rd_idx  = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
   assign wr_hit  = wr_idx < IDX_W'(REG_COUNT);
   assign rd_hit  = rd_idx < IDX_W'(REG_COUNT);
   assign ar_fire = s_axil_arvalid && !rvalid_q;

   // Sub-word address bits and protection attributes carry no meaning for this bank.
   assign unused_ok = ^{s_axil_awprot, s_axil_arprot, wr_addr, s_axil_araddr};

   always_comb begin
      regs_d   = regs_q;
      pulse_d  = '0;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (wr_commit) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_hit ? AXIL_RESP_OKAY : ERR_RESP;
         for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_hit && wr_idx == IDX_W'(i)) begin
               pulse_d[i] = 1'b1;
               for (int b = 0; b < STRB_WIDTH; b++)
                  if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
            end
         end
      end else if (bvalid_q && s_axil_bready) begin
         bvalid_d = 1'b0;
      end
      // Read samples regs_q, so a same-edge write to the same register is not yet visible.
      if (ar_fire) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_hit ? AXIL_RESP_OKAY : ERR_RESP;
         rdata_d  = '0;
         for (int i = 0; i < REG_COUNT; i++)
            if (rd_hit && rd_idx == IDX_W'(i)) rdata_d = regs_q[i];
      end else if (rvalid_q && s_axil_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= RESET_VALUE;
         pulse_q  <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= '0;
         rvalid_q <= 1'b0;
         rresp_q  <= '0;
         rdata_q  <= '0;
      end else begin
         regs_q   <= regs_d;
         pulse_q  <= pulse_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      for (int i = 0; i < REG_COUNT; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
   end

   assign reg_wr_pulse   = pulse_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = bresp_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rresp   = rresp_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_arready = !rvalid_q;

endmodule
